// File: rtl/alu_ctrl_32.sv
// rtl/alu_ctrl_32.sv - operation sequencer in front of the 32-bit combinational ALU
//
// Accepts one operation at a time, drives the ALU with latched operands and
// captures its 64-bit result. DIV is computed locally by a 32-iteration
// restoring divider. Each result is presented with a one-cycle out_valid pulse.
//
// Ports:
//   in_clk, in_reset_n           clock, asynchronous active-low reset
//   in_valid / out_ready         request handshake (in_a, in_b, in_opcode)
//   out_alu_a/b/opcode           latched operands to the ALU
//   in_alu_result                combinational ALU result
//   out_valid                    one-cycle pulse qualifying out_result / out_div_by_zero
//   out_result                   {HI,LO}; for DIV HI = remainder, LO = quotient
//   out_div_by_zero              DIV was issued with in_b == 0
//   out_busy                     controller is not idle

module alu_ctrl_32 #(
   parameter bit DIV_SIGNED = 1'b1
) (
   input  logic        in_clk,
   input  logic        in_reset_n,
   input  logic        in_valid,
   output logic        out_ready,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   input  logic [3:0]  in_opcode,
   output logic [31:0] out_alu_a,
   output logic [31:0] out_alu_b,
   output logic [3:0]  out_alu_opcode,
   input  logic [63:0] in_alu_result,
   output logic        out_valid,
   output logic [63:0] out_result,
   output logic        out_div_by_zero,
   output logic        out_busy
);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_EXEC = 3'd1;
   localparam logic [2:0] ST_DIV  = 3'd2;
   localparam logic [2:0] ST_FIX  = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   localparam logic [3:0] OP_DIV = 4'b1001;

   logic [2:0]  state_q, state_d;
   logic [4:0]  count_q, count_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [3:0]  op_q, op_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] dvs_q, dvs_d;
   logic [63:0] res_q, res_d;
   logic        valid_q, valid_d;
   logic        dbz_q, dbz_d;

   logic [32:0] sh_rem;
   logic [33:0] trial;
   logic        trial_ok;
   logic [31:0] q_fix;
   logic [31:0] r_fix;

   // Shifted partial remainder can reach 2*divisor-1, so it needs 33 bits.
   // The trial difference is non-negative only when both top bits are clear.
   always_comb begin
      sh_rem   = {rem_q, quo_q[31]};
      trial    = {1'b0, sh_rem} - {2'b00, dvs_q};
      trial_ok = (trial[33:32] == 2'b00);
   end

   // Sign correction; 0x80000000 / -1 wraps naturally to Q = 0x80000000, R = 0.
   always_comb begin
      q_fix = quo_q;
      r_fix = rem_q;
      if (DIV_SIGNED) begin
         if (a_q[31] ^ b_q[31]) q_fix = 32'd0 - quo_q;
         if (a_q[31])           r_fix = 32'd0 - rem_q;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      res_d   = res_q;
      valid_d = valid_q;
      dbz_d   = dbz_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d  = in_a;
               b_d  = in_b;
               op_d = in_opcode;
               if (in_opcode == OP_DIV && in_b != 32'd0) begin
                  state_d = ST_DIV;
                  count_d = 5'd0;
                  rem_d   = 32'd0;
                  quo_d   = (DIV_SIGNED && in_a[31]) ? 32'd0 - in_a : in_a;
                  dvs_d   = (DIV_SIGNED && in_b[31]) ? 32'd0 - in_b : in_b;
               end else begin
                  state_d = ST_EXEC;
               end
            end
         end
         ST_EXEC: begin
            // Only a zero divisor reaches EXEC with the DIV opcode.
            if (op_q == OP_DIV) begin
               res_d = {a_q, 32'hFFFF_FFFF};
               dbz_d = 1'b1;
            end else begin
               res_d = in_alu_result;
            end
            valid_d = 1'b1;
            state_d = ST_DONE;
         end
         ST_DIV: begin
            rem_d   = trial_ok ? trial[31:0] : sh_rem[31:0];
            quo_d   = {quo_q[30:0], trial_ok};
            count_d = count_q + 5'd1;
            if (count_q == 5'd31) state_d = ST_FIX;
         end
         ST_FIX: begin
            res_d   = {r_fix, q_fix};
            valid_d = 1'b1;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            valid_d = 1'b0;
            dbz_d   = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge in_clk or negedge in_reset_n) begin
      if (!in_reset_n) begin
         state_q <= ST_IDLE;
         count_q <= 5'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         op_q    <= 4'd0;
         rem_q   <= 32'd0;
         quo_q   <= 32'd0;
         dvs_q   <= 32'd0;
         res_q   <= 64'd0;
         valid_q <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         res_q   <= res_d;
         valid_q <= valid_d;
         dbz_q   <= dbz_d;
      end
   end

   assign out_ready       = (state_q == ST_IDLE) && in_reset_n;
   assign out_busy        = (state_q != ST_IDLE);
   assign out_alu_a       = a_q;
   assign out_alu_b       = b_q;
   assign out_alu_opcode  = op_q;
   assign out_valid       = valid_q;
   assign out_result      = res_q;
   assign out_div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_ctrl_32.sv
// tb/tb_alu_ctrl_32.sv - randomized self-checking bench for alu_ctrl_32

module tb_alu_ctrl_32;

   localparam bit DS = 1'b1;

   logic        in_clk = 1'b0;
   logic        in_reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic [3:0]  in_opcode = '0;
   logic [31:0] out_alu_a;
   logic [31:0] out_alu_b;
   logic [3:0]  out_alu_opcode;
   logic [63:0] in_alu_result;
   logic        out_valid;
   logic [63:0] out_result;
   logic        out_div_by_zero;
   logic        out_busy;

   alu_ctrl_32 #(.DIV_SIGNED(DS)) dut (
      .in_clk(in_clk), .in_reset_n(in_reset_n), .in_valid(in_valid), .out_ready(out_ready),
      .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode),
      .out_alu_a(out_alu_a), .out_alu_b(out_alu_b), .out_alu_opcode(out_alu_opcode),
      .in_alu_result(in_alu_result), .out_valid(out_valid), .out_result(out_result),
      .out_div_by_zero(out_div_by_zero), .out_busy(out_busy)
   );

   always #5 in_clk = ~in_clk;

   int cyc = 0;
   always @(posedge in_clk) cyc <= cyc + 1;

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // Combinational ALU stand-in (DIV slot unpopulated, undefined opcodes give 0).
   function automatic logic [63:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      logic [63:0] xa, xb;
      xa = {32'd0, a};
      xb = {32'd0, b};
      case (op)
         4'd0:    return {32'd0, a + b};
         4'd1:    return {32'd0, a - b};
         4'd2:    return {32'd0, a & b};
         4'd3:    return {32'd0, a | b};
         4'd4:    return {32'd0, a ^ b};
         4'd5:    return {32'd0, a << b[4:0]};
         4'd6:    return {32'd0, a >> b[4:0]};
         4'd7:    return {32'd0, $signed(a) >>> b[4:0]};
         4'd8:    return xa * xb;
         4'd10:   return {32'd0, 32'd0 - a};
         4'd11:   return {32'd0, ~a};
         default: return 64'd0;
      endcase
   endfunction

   always_comb in_alu_result = alu_fn(out_alu_a, out_alu_b, out_alu_opcode);

   // Expected {div_by_zero, result} straight from arithmetic rules.
   function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      longint sa, sb, q, r;
      if (op != 4'd9) return {1'b0, alu_fn(a, b, op)};
      if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
      if (DS) begin
         sa = $signed(a);
         sb = $signed(b);
      end else begin
         sa = longint'(a);
         sb = longint'(b);
      end
      q = sa / sb;
      r = sa % sb;
      return {1'b0, r[31:0], q[31:0]};
   endfunction

   typedef struct {
      int          vcyc;
      logic [63:0] res;
      logic        dbz;
   } exp_t;

   exp_t        expq[$];
   bit          pend_v = 0;
   int          pend_acc, pend_vcyc;
   logic [31:0] pend_a, pend_b;
   logic [3:0]  pend_op;
   logic [63:0] pend_res;
   logic        pend_dbz;

   logic [31:0] lat_a = '0;
   logic [31:0] lat_b = '0;
   logic [3:0]  lat_op = '0;
   logic [63:0] last_res = '0;
   int          busy_lo = 1;
   int          busy_hi = 0;

   task automatic model_reset();
      expq.delete();
      pend_v   = 0;
      lat_a    = '0;
      lat_b    = '0;
      lat_op   = '0;
      last_res = '0;
      busy_lo  = 1;
      busy_hi  = 0;
   endtask

   // Compare process: every falling edge, all outputs against the model.
   always @(negedge in_clk) begin
      logic exp_v, exp_dbz, busy;
      if (pend_v && cyc == pend_acc) begin
         lat_a   = pend_a;
         lat_b   = pend_b;
         lat_op  = pend_op;
         busy_lo = pend_acc;
         busy_hi = pend_vcyc;
         expq.push_back('{pend_vcyc, pend_res, pend_dbz});
         pend_v = 0;
      end
      exp_v   = 1'b0;
      exp_dbz = 1'b0;
      if (expq.size() > 0 && expq[0].vcyc == cyc) begin
         exp_v    = 1'b1;
         exp_dbz  = expq[0].dbz;
         last_res = expq[0].res;
         void'(expq.pop_front());
      end
      busy = (cyc >= busy_lo) && (cyc <= busy_hi);
      chk("out_valid", out_valid, exp_v);
      chk("out_result", out_result, last_res);
      chk("out_div_by_zero", out_div_by_zero, exp_dbz);
      chk("out_busy", out_busy, busy);
      chk("out_ready", out_ready, !busy && in_reset_n);
      chk("out_alu_a", out_alu_a, lat_a);
      chk("out_alu_b", out_alu_b, lat_b);
      chk("out_alu_opcode", out_alu_opcode, lat_op);
   end

   // Called at a falling edge; returns at the falling edge right after acceptance.
   // in_valid is left high so back-to-back issue is possible.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                        input bit lit_en, input logic [64:0] lit);
      logic [64:0] m;
      int n;
      m = model(a, b, op);
      if (lit_en) chk("model_literal", m, lit);
      in_a = a;
      in_b = b;
      in_opcode = op;
      in_valid = 1'b1;
      n = 0;
      while (!out_ready && n < 200) begin
         @(negedge in_clk);
         n++;
      end
      if (!out_ready) begin
         chk("accept_timeout", 65'd0, 65'd1);
         in_valid = 1'b0;
         return;
      end
      pend_acc  = cyc + 1;
      pend_vcyc = pend_acc + ((op == 4'd9 && b != 32'd0) ? 33 : 1);
      pend_a    = a;
      pend_b    = b;
      pend_op   = op;
      pend_res  = m[63:0];
      pend_dbz  = m[64];
      pend_v    = 1;
      @(negedge in_clk);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(negedge in_clk);
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic [3:0]  rop;
      int n;
      repeat (2) @(negedge in_clk);
      #2 in_reset_n = 1'b1;
      @(negedge in_clk);

      issue(32'h0000FFFF, 32'h1, 4'd0, 1, {1'b0, 64'h0000_0000_0001_0000});
      idle(2);
      issue(32'd34, 32'd36, 4'd9, 1, {1'b0, 32'd34, 32'd0});
      idle(1);
      issue(32'hFFFF_FFF9, 32'd2, 4'd9, 1, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
      idle(1);
      issue(32'h8000_0000, 32'hFFFF_FFFF, 4'd9, 1, {1'b0, 32'd0, 32'h8000_0000});
      idle(1);
      issue(32'h1234_5678, 32'd0, 4'd9, 1, {1'b1, 64'h1234_5678_FFFF_FFFF});
      idle(1);
      issue(32'hFFFF_FFF3, 32'hB, 4'd8, 1, {1'b0, 64'h0000_000A_FFFF_FF71});
      issue(32'h0000_FFFF, 32'h0000_00FF, 4'd1, 1, {1'b0, 64'h0000_0000_0000_FF00});
      idle(1);
      issue(32'hDEAD_BEEF, 32'h5, 4'd12, 1, {1'b0, 64'd0});
      idle(3);

      // Reset during the 10th divider iteration.
      issue(32'd1000, 32'd7, 4'd9, 0, '0);
      in_valid = 1'b0;
      repeat (10) @(posedge in_clk);
      #3 in_reset_n = 1'b0;
      model_reset();
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_result", out_result, 64'd0);
      chk("rst_out_busy", out_busy, 1'b0);
      chk("rst_out_ready", out_ready, 1'b0);
      repeat (2) @(negedge in_clk);
      #2 in_reset_n = 1'b1;
      @(negedge in_clk);
      issue(32'd1, 32'd1, 4'd0, 1, {1'b0, 64'd2});
      idle(2);

      for (int i = 0; i < 40; i++) begin
         ra  = $urandom;
         rop = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 2) == 0) rop = 4'd9;
         case ($urandom_range(0, 5))
            0:       rb = 32'd0;
            1, 2:    rb = $urandom_range(1, 20);
            3:       rb = 32'd0 - 32'($urandom_range(1, 20));
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 9) == 0) begin
            ra = 32'h8000_0000;
            rb = 32'hFFFF_FFFF;
         end
         issue(ra, rb, rop, 0, '0);
         if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 3));
      end
      in_valid = 1'b0;

      n = 0;
      while ((expq.size() > 0 || pend_v) && n < 100) begin
         @(negedge in_clk);
         n++;
      end
      chk("drain", 65'(expq.size()), 65'd0);
      repeat (3) @(negedge in_clk);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
